// File: rtl/pcie_cq_cc_pkg.sv
// ---------------------------------------------------------------------------
// pcie_cq_cc_pkg
// Shared definitions for the CQ/CC completer slice:
//   - request type codes carried in the CQ descriptor
//   - completion status codes written into the CC descriptor
//   - bit positions of the CQ and CC descriptor fields (128-bit datapath)
//   - responder state enumeration
// ---------------------------------------------------------------------------
package pcie_cq_cc_pkg;

    // Request type codes (CQ descriptor bits [78:75])
    localparam logic [3:0] REQ_MEM_RD = 4'b0000;
    localparam logic [3:0] REQ_MEM_WR = 4'b0001;
    localparam logic [3:0] REQ_IO_RD  = 4'b0010;
    localparam logic [3:0] REQ_IO_WR  = 4'b0011;

    // Completion status codes
    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;

    // CQ descriptor field LSB positions
    localparam int CQ_ADDR_LSB   = 2;
    localparam int CQ_DCOUNT_LSB = 64;
    localparam int CQ_TYPE_LSB   = 75;
    localparam int CQ_REQID_LSB  = 80;
    localparam int CQ_TAG_LSB    = 96;
    localparam int CQ_BAR_LSB    = 112;
    localparam int CQ_TC_LSB     = 121;
    localparam int CQ_ATTR_LSB   = 124;

    // CC descriptor field LSB positions
    localparam int CC_LADDR_LSB   = 0;
    localparam int CC_BCOUNT_LSB  = 16;
    localparam int CC_DCOUNT_LSB  = 32;
    localparam int CC_STATUS_LSB  = 43;
    localparam int CC_REQID_LSB   = 48;
    localparam int CC_TAG_LSB     = 64;
    localparam int CC_CPLID_LSB   = 72;
    localparam int CC_CPLID_EN    = 88;
    localparam int CC_TC_LSB      = 89;
    localparam int CC_ATTR_LSB    = 92;
    localparam int CC_DATA_LSB    = 96;

    // Responder states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        CPL     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/pcie_be_to_bytecount.sv
// ---------------------------------------------------------------------------
// pcie_be_to_bytecount
// Combinational conversion of a 1-DW request's first byte enable into the
// completion's low address bits and byte count.
//   firstBe_i    : first DW byte enables of the request
//   lowerAddr_o  : index of the lowest enabled byte (0 when no byte enabled)
//   byteCount_o  : highest enabled byte - lowest enabled byte + 1
//                  (1 when no byte enabled)
// ---------------------------------------------------------------------------
module pcie_be_to_bytecount (
    input  logic [3:0]  firstBe_i,
    output logic [1:0]  lowerAddr_o,
    output logic [12:0] byteCount_o
);

    logic [1:0] lowByte;
    logic [1:0] highByte;

    // Priority encode from both ends; the span between them is the byte count.
    always_comb begin
        lowByte  = 2'd0;
        highByte = 2'd0;

        if (firstBe_i[0])      lowByte = 2'd0;
        else if (firstBe_i[1]) lowByte = 2'd1;
        else if (firstBe_i[2]) lowByte = 2'd2;
        else if (firstBe_i[3]) lowByte = 2'd3;

        if (firstBe_i[3])      highByte = 2'd3;
        else if (firstBe_i[2]) highByte = 2'd2;
        else if (firstBe_i[1]) highByte = 2'd1;
        else                   highByte = 2'd0;

        lowerAddr_o = lowByte;
        if (firstBe_i == 4'b0000) begin
            byteCount_o = 13'd1;
        end else begin
            byteCount_o = 13'd1 + {11'd0, highByte} - {11'd0, lowByte};
        end
    end

endmodule

// File: rtl/pcie_cq_cc_responder.sv
// ---------------------------------------------------------------------------
// pcie_cq_cc_responder
// Endpoint completer: serves 1-DW memory reads/writes from the CQ stream
// against a small BAR0 register file and returns completions on CC.
//   user_clk / reset_n     : clock, asynchronous active-low reset
//   s_axis_cq_*            : requester requests in (descriptor beat first)
//   m_axis_cc_*            : completions out, single beat, held until ready
//   reg_wr_pulse/addr      : one-cycle strobe and index for each BAR0 write
//   ur_count               : saturating count of unsupported requests
// ---------------------------------------------------------------------------
module pcie_cq_cc_responder
    import pcie_cq_cc_pkg::*;
#(
    parameter int          C_DATA_WIDTH        = 128,
    parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int          AXI4_CQ_TUSER_WIDTH = 88,
    parameter int          AXI4_CC_TUSER_WIDTH = 33,
    parameter logic [15:0] COMPLETER_ID        = 16'h0100,
    parameter int          REG_ADDR_WIDTH      = 4
) (
    input  logic                           user_clk,
    input  logic                           reset_n,

    input  logic [C_DATA_WIDTH-1:0]        s_axis_cq_tdata,
    input  logic [KEEP_WIDTH-1:0]          s_axis_cq_tkeep,
    input  logic [AXI4_CQ_TUSER_WIDTH-1:0] s_axis_cq_tuser,
    input  logic                           s_axis_cq_tlast,
    input  logic                           s_axis_cq_tvalid,
    output logic                           s_axis_cq_tready,

    output logic [C_DATA_WIDTH-1:0]        m_axis_cc_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_cc_tkeep,
    output logic [AXI4_CC_TUSER_WIDTH-1:0] m_axis_cc_tuser,
    output logic                           m_axis_cc_tlast,
    output logic                           m_axis_cc_tvalid,
    input  logic                           m_axis_cc_tready,

    output logic                           reg_wr_pulse,
    output logic [REG_ADDR_WIDTH-1:0]      reg_wr_addr,
    output logic [7:0]                     ur_count
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

    state_t state_q, state_d;
    logic   cqReady_q;
    logic   pendCpl_q, pendCpl_d;
    logic   urFlag_q, urFlag_d;
    logic   urInc;
    logic   wrFire;

    logic [REG_ADDR_WIDTH-1:0] regIdx_q;
    logic [4:0]                addrLo_q;
    logic [15:0]               reqId_q;
    logic [7:0]                tag_q;
    logic [2:0]                tc_q;
    logic [2:0]                attr_q;
    logic [3:0]                firstBe_q;

    logic [31:0] regFile_q [NUM_REGS];

    logic [C_DATA_WIDTH-1:0] ccData_q;
    logic [KEEP_WIDTH-1:0]   ccKeep_q;
    logic                    ccLast_q;
    logic                    ccValid_q;
    logic [C_DATA_WIDTH-1:0] cplData;

    logic                      wrPulse_q;
    logic [REG_ADDR_WIDTH-1:0] wrAddr_q;
    logic [7:0]                urCount_q;

    logic        cqFire;
    logic        descFire;
    logic [3:0]  descType;
    logic [10:0] descDcount;
    logic [2:0]  descBar;
    logic        descOk;
    logic [1:0]  beLowAddr;
    logic [12:0] beByteCount;

    logic unusedCq;

    assign cqFire     = s_axis_cq_tvalid && cqReady_q;
    assign descFire   = cqFire && (state_q == IDLE);
    assign descType   = s_axis_cq_tdata[CQ_TYPE_LSB +: 4];
    assign descDcount = s_axis_cq_tdata[CQ_DCOUNT_LSB +: 11];
    assign descBar    = s_axis_cq_tdata[CQ_BAR_LSB +: 3];
    assign descOk     = (descDcount == 11'd1) && (descBar == 3'd0);

    assign unusedCq = ^{s_axis_cq_tkeep, s_axis_cq_tuser[AXI4_CQ_TUSER_WIDTH-1:4],
                        s_axis_cq_tdata[63:32], s_axis_cq_tdata[79],
                        s_axis_cq_tdata[111:104], s_axis_cq_tdata[120:115],
                        s_axis_cq_tdata[127]};

    pcie_be_to_bytecount u_be2bc (
        .firstBe_i   (firstBe_q),
        .lowerAddr_o (beLowAddr),
        .byteCount_o (beByteCount)
    );

    // Next-state decode. pendCpl remembers where DRAIN hands off to, urFlag
    // selects the UR flavour of the completion built in CPL.
    always_comb begin
        state_d   = state_q;
        pendCpl_d = pendCpl_q;
        urFlag_d  = urFlag_q;
        urInc     = 1'b0;
        wrFire    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cqFire) begin
                    case (descType)
                        REQ_MEM_RD: begin
                            urFlag_d  = !descOk;
                            urInc     = !descOk;
                            pendCpl_d = 1'b1;
                            state_d   = s_axis_cq_tlast ? CPL : DRAIN;
                        end
                        REQ_MEM_WR: begin
                            pendCpl_d = 1'b0;
                            if (s_axis_cq_tlast) begin
                                urInc   = 1'b1;
                                state_d = IDLE;
                            end else if (descOk) begin
                                state_d = WR_DATA;
                            end else begin
                                urInc   = 1'b1;
                                state_d = DRAIN;
                            end
                        end
                        REQ_IO_RD, REQ_IO_WR: begin
                            urFlag_d  = 1'b1;
                            urInc     = 1'b1;
                            pendCpl_d = 1'b1;
                            state_d   = s_axis_cq_tlast ? CPL : DRAIN;
                        end
                        default: begin
                            urInc     = 1'b1;
                            pendCpl_d = 1'b0;
                            state_d   = s_axis_cq_tlast ? IDLE : DRAIN;
                        end
                    endcase
                end
            end
            WR_DATA: begin
                if (cqFire) begin
                    wrFire    = 1'b1;
                    pendCpl_d = 1'b0;
                    state_d   = s_axis_cq_tlast ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (cqFire && s_axis_cq_tlast) begin
                    state_d = pendCpl_q ? CPL : IDLE;
                end
            end
            CPL: begin
                if (ccValid_q && m_axis_cc_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register. Ready is registered from the next state so that it is
    // low in reset and drops in the same edge that enters CPL.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cqReady_q <= 1'b0;
            pendCpl_q <= 1'b0;
            urFlag_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cqReady_q <= (state_d != CPL);
            pendCpl_q <= pendCpl_d;
            urFlag_q  <= urFlag_d;
        end
    end

    // Descriptor fields needed after the descriptor beat has gone.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            regIdx_q  <= '0;
            addrLo_q  <= '0;
            reqId_q   <= '0;
            tag_q     <= '0;
            tc_q      <= '0;
            attr_q    <= '0;
            firstBe_q <= '0;
        end else if (descFire) begin
            regIdx_q  <= s_axis_cq_tdata[CQ_ADDR_LSB +: REG_ADDR_WIDTH];
            addrLo_q  <= s_axis_cq_tdata[CQ_ADDR_LSB +: 5];
            reqId_q   <= s_axis_cq_tdata[CQ_REQID_LSB +: 16];
            tag_q     <= s_axis_cq_tdata[CQ_TAG_LSB +: 8];
            tc_q      <= s_axis_cq_tdata[CQ_TC_LSB +: 3];
            attr_q    <= s_axis_cq_tdata[CQ_ATTR_LSB +: 3];
            firstBe_q <= s_axis_cq_tuser[3:0];
        end
    end

    // BAR0 register file; byte lanes gated by the latched first byte enable.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regFile_q[r] <= 32'd0;
            end
        end else if (wrFire) begin
            for (int b = 0; b < 4; b++) begin
                if (firstBe_q[b]) begin
                    regFile_q[regIdx_q][8*b +: 8] <= s_axis_cq_tdata[8*b +: 8];
                end
            end
        end
    end

    // Write strobe follows the data beat by one cycle.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPulse_q <= 1'b0;
            wrAddr_q  <= '0;
        end else begin
            wrPulse_q <= wrFire;
            if (wrFire) begin
                wrAddr_q <= regIdx_q;
            end
        end
    end

    // Saturating unsupported-request counter.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            urCount_q <= 8'd0;
        end else if (urInc && (urCount_q != 8'hFF)) begin
            urCount_q <= urCount_q + 8'd1;
        end
    end

    // Completion descriptor and payload from the latched request.
    always_comb begin
        cplData = '0;
        if (urFlag_q) begin
            cplData[CC_BCOUNT_LSB +: 13] = 13'd4;
            cplData[CC_STATUS_LSB +: 3]  = CPL_UR;
        end else begin
            cplData[CC_LADDR_LSB +: 7]   = {addrLo_q, beLowAddr};
            cplData[CC_BCOUNT_LSB +: 13] = beByteCount;
            cplData[CC_DCOUNT_LSB +: 11] = 11'd1;
            cplData[CC_STATUS_LSB +: 3]  = CPL_SC;
            cplData[CC_DATA_LSB +: 32]   = regFile_q[regIdx_q];
        end
        cplData[CC_REQID_LSB +: 16] = reqId_q;
        cplData[CC_TAG_LSB +: 8]    = tag_q;
        cplData[CC_CPLID_LSB +: 16] = COMPLETER_ID;
        cplData[CC_CPLID_EN]        = 1'b1;
        cplData[CC_TC_LSB +: 3]     = tc_q;
        cplData[CC_ATTR_LSB +: 3]   = attr_q;
    end

    // CC output register: loaded on the first CPL cycle, frozen until the
    // handshake, cleared afterwards. Reset abandons any beat in flight.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            ccValid_q <= 1'b0;
            ccData_q  <= '0;
            ccKeep_q  <= '0;
            ccLast_q  <= 1'b0;
        end else if ((state_q == CPL) && !ccValid_q) begin
            ccValid_q <= 1'b1;
            ccData_q  <= cplData;
            ccKeep_q  <= urFlag_q ? 4'b0111 : 4'b1111;
            ccLast_q  <= 1'b1;
        end else if (ccValid_q && m_axis_cc_tready) begin
            ccValid_q <= 1'b0;
            ccData_q  <= '0;
            ccKeep_q  <= '0;
            ccLast_q  <= 1'b0;
        end
    end

    assign s_axis_cq_tready = cqReady_q;
    assign m_axis_cc_tdata  = ccData_q;
    assign m_axis_cc_tkeep  = ccKeep_q;
    assign m_axis_cc_tuser  = '0;
    assign m_axis_cc_tlast  = ccLast_q;
    assign m_axis_cc_tvalid = ccValid_q;
    assign reg_wr_pulse     = wrPulse_q;
    assign reg_wr_addr      = wrAddr_q;
    assign ur_count         = urCount_q;

endmodule

// File: tb/tb_pcie_cq_cc_responder.sv
// ---------------------------------------------------------------------------
// tb_pcie_cq_cc_responder
// Scoreboard bench: each request pushes its expected completion / write
// strobe, monitors pop and compare when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_pcie_cq_cc_responder;

    localparam logic [15:0] CPL_ID = 16'h0100;

    logic         user_clk;
    logic         reset_n;
    logic [127:0] s_axis_cq_tdata;
    logic [3:0]   s_axis_cq_tkeep;
    logic [87:0]  s_axis_cq_tuser;
    logic         s_axis_cq_tlast;
    logic         s_axis_cq_tvalid;
    logic         s_axis_cq_tready;
    logic [127:0] m_axis_cc_tdata;
    logic [3:0]   m_axis_cc_tkeep;
    logic [32:0]  m_axis_cc_tuser;
    logic         m_axis_cc_tlast;
    logic         m_axis_cc_tvalid;
    logic         m_axis_cc_tready;
    logic         reg_wr_pulse;
    logic [3:0]   reg_wr_addr;
    logic [7:0]   ur_count;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
    } cpl_t;

    cpl_t        cplQ[$];
    logic [3:0]  wrQ[$];
    logic [31:0] modelRegs [16];
    int          expUr;
    int          testsRun;
    int          testsFailed;

    pcie_cq_cc_responder dut (
        .user_clk         (user_clk),
        .reset_n          (reset_n),
        .s_axis_cq_tdata  (s_axis_cq_tdata),
        .s_axis_cq_tkeep  (s_axis_cq_tkeep),
        .s_axis_cq_tuser  (s_axis_cq_tuser),
        .s_axis_cq_tlast  (s_axis_cq_tlast),
        .s_axis_cq_tvalid (s_axis_cq_tvalid),
        .s_axis_cq_tready (s_axis_cq_tready),
        .m_axis_cc_tdata  (m_axis_cc_tdata),
        .m_axis_cc_tkeep  (m_axis_cc_tkeep),
        .m_axis_cc_tuser  (m_axis_cc_tuser),
        .m_axis_cc_tlast  (m_axis_cc_tlast),
        .m_axis_cc_tvalid (m_axis_cc_tvalid),
        .m_axis_cc_tready (m_axis_cc_tready),
        .reg_wr_pulse     (reg_wr_pulse),
        .reg_wr_addr      (reg_wr_addr),
        .ur_count         (ur_count)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] beLsb(input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) return i[1:0];
        end
        return 2'd0;
    endfunction

    function automatic logic [12:0] beSpan(input logic [3:0] be);
        int lo, hi;
        lo = -1;
        hi = -1;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        end
        if (lo < 0) return 13'd1;
        return 13'(hi - lo + 1);
    endfunction

    function automatic logic [127:0] makeDesc(input logic [3:0] typ, input logic [61:0] addr,
                                              input logic [10:0] dcount, input logic [2:0] bar,
                                              input logic [7:0] tag);
        logic [127:0] d;
        d = '0;
        d[63:2]    = addr;
        d[74:64]   = dcount;
        d[78:75]   = typ;
        d[95:80]   = 16'hA5C0 ^ {8'd0, tag};
        d[103:96]  = tag;
        d[114:112] = bar;
        d[123:121] = tag[2:0];
        d[126:124] = tag[5:3];
        return d;
    endfunction

    function automatic logic [127:0] expCpl(input bit ur, input logic [61:0] addr,
                                            input logic [3:0] be, input logic [7:0] tag,
                                            input logic [31:0] data);
        logic [127:0] d;
        d = '0;
        if (ur) begin
            d[28:16] = 13'd4;
            d[45:43] = 3'b001;
        end else begin
            d[6:0]   = {addr[4:0], beLsb(be)};
            d[28:16] = beSpan(be);
            d[42:32] = 11'd1;
            d[127:96] = data;
        end
        d[63:48] = 16'hA5C0 ^ {8'd0, tag};
        d[71:64] = tag;
        d[87:72] = CPL_ID;
        d[88]    = 1'b1;
        d[91:89] = tag[2:0];
        d[94:92] = tag[5:3];
        return d;
    endfunction

    function automatic int satInc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Drive one CQ beat (called just after a rising edge) and hold it until
    // the DUT accepts it, with a bounded wait.
    task automatic applyStimulus(input logic [127:0] data, input logic [3:0] be,
                                 input logic last);
        bit accepted;
        s_axis_cq_tdata  = data;
        s_axis_cq_tuser  = {84'd0, be};
        s_axis_cq_tlast  = last;
        s_axis_cq_tvalid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge user_clk);
            accepted = s_axis_cq_tready;
            @(posedge user_clk);
            #1;
        end
        s_axis_cq_tvalid = 1'b0;
        s_axis_cq_tlast  = 1'b0;
        if (!accepted) checkOutput("cq_accept_timeout", 0, 1);
    endtask

    task automatic doRead(input logic [61:0] addr, input logic [3:0] be,
                          input logic [10:0] dcount, input logic [2:0] bar,
                          input logic [7:0] tag);
        cpl_t e;
        bit   ur;
        ur = !(dcount == 11'd1 && bar == 3'd0);
        if (ur) expUr = satInc(expUr);
        e.data = expCpl(ur, addr, be, tag, modelRegs[addr[3:0]]);
        e.keep = ur ? 4'b0111 : 4'b1111;
        cplQ.push_back(e);
        applyStimulus(makeDesc(4'b0000, addr, dcount, 3'(bar), tag), be, 1'b1);
    endtask

    task automatic doWrite(input logic [61:0] addr, input logic [3:0] be,
                           input logic [31:0] data, input logic [2:0] bar);
        applyStimulus(makeDesc(4'b0001, addr, 11'd1, bar, 8'h33), be, 1'b0);
        if (bar == 3'd0) begin
            wrQ.push_back(addr[3:0]);
            for (int b = 0; b < 4; b++) begin
                if (be[b]) modelRegs[addr[3:0]][8*b +: 8] = data[8*b +: 8];
            end
        end else begin
            expUr = satInc(expUr);
        end
        applyStimulus({96'd0, data}, be, 1'b1);
    endtask

    // IO and unsupported types; IO requests earn a UR completion.
    task automatic doOther(input logic [3:0] typ, input int beats, input logic [7:0] tag);
        cpl_t e;
        expUr = satInc(expUr);
        if (typ == 4'b0010 || typ == 4'b0011) begin
            e.data = expCpl(1'b1, 62'h0, 4'hF, tag, 32'd0);
            e.keep = 4'b0111;
            cplQ.push_back(e);
        end
        applyStimulus(makeDesc(typ, 62'h2, 11'd1, 3'd0, tag), 4'hF, beats == 1);
        for (int i = 1; i < beats; i++) begin
            applyStimulus({32'hC0DE0000 + 32'(i), 96'd0}, 4'hF, i == beats - 1);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 200; i++) begin
            if (cplQ.size() == 0 && wrQ.size() == 0) break;
            @(posedge user_clk);
            #1;
        end
        if (cplQ.size() != 0 || wrQ.size() != 0)
            checkOutput("drain_timeout", 128'(cplQ.size() + wrQ.size()), 0);
        repeat (3) @(posedge user_clk);
        #1;
    endtask

    task automatic waitCcValid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge user_clk);
            seen = m_axis_cc_tvalid;
        end
        if (!seen) checkOutput("cc_valid_timeout", 0, 1);
        @(posedge user_clk);
        #1;
    endtask

    // Completion monitor: compare each accepted CC beat with the queue head.
    always @(negedge user_clk) begin : ccMonitor
        cpl_t e;
        if (reset_n && m_axis_cc_tvalid && m_axis_cc_tready) begin
            checkOutput("cc_expected", 128'(cplQ.size() != 0), 1);
            if (cplQ.size() != 0) begin
                e = cplQ.pop_front();
                checkOutput("cc_tdata", m_axis_cc_tdata, e.data);
                checkOutput("cc_tkeep", 128'(m_axis_cc_tkeep), 128'(e.keep));
                checkOutput("cc_tlast", 128'(m_axis_cc_tlast), 1);
            end
        end
    end

    // Write strobe monitor.
    always @(negedge user_clk) begin : wrMonitor
        logic [3:0] a;
        if (reset_n && reg_wr_pulse) begin
            checkOutput("wr_expected", 128'(wrQ.size() != 0), 1);
            if (wrQ.size() != 0) begin
                a = wrQ.pop_front();
                checkOutput("wr_addr", 128'(reg_wr_addr), 128'(a));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [127:0] held;
        testsRun         = 0;
        testsFailed      = 0;
        expUr            = 0;
        for (int r = 0; r < 16; r++) modelRegs[r] = 32'd0;
        s_axis_cq_tdata  = '0;
        s_axis_cq_tkeep  = 4'hF;
        s_axis_cq_tuser  = '0;
        s_axis_cq_tlast  = 1'b0;
        s_axis_cq_tvalid = 1'b0;
        m_axis_cc_tready = 1'b1;
        reset_n          = 1'b0;

        // Reset state
        repeat (3) @(posedge user_clk);
        #1;
        checkOutput("rst_cq_tready", 128'(s_axis_cq_tready), 0);
        checkOutput("rst_cc_tvalid", 128'(m_axis_cc_tvalid), 0);
        checkOutput("rst_cc_tdata", m_axis_cc_tdata, 0);
        checkOutput("rst_ur_count", 128'(ur_count), 0);
        checkOutput("rst_wr_pulse", 128'(reg_wr_pulse), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge user_clk);
        #1;
        checkOutput("idle_cq_tready", 128'(s_axis_cq_tready), 1);

        // Full-word write then read back
        doWrite(62'h3, 4'hF, 32'hDEADBEEF, 3'd0);
        doRead(62'h3, 4'hF, 11'd1, 3'd0, 8'h12);
        waitIdle();
        checkOutput("ur_after_rw", 128'(ur_count), 128'(expUr));

        // Partial byte enables, aliased address, first_be=0 write
        doWrite(62'h5, 4'b0110, 32'h11223344, 3'd0);
        doRead(62'h25, 4'b0110, 11'd1, 3'd0, 8'h13);
        doWrite(62'h5, 4'b0000, 32'hFFFFFFFF, 3'd0);
        doRead(62'h5, 4'b1000, 11'd1, 3'd0, 8'h14);
        doRead(62'h15, 4'b0000, 11'd1, 3'd0, 8'h15);
        waitIdle();

        // Unsupported reads/writes
        doRead(62'h7, 4'hF, 11'd2, 3'd0, 8'h21);
        waitIdle();
        checkOutput("ur_dcount2", 128'(ur_count), 128'(expUr));
        doWrite(62'h7, 4'hF, 32'h12345678, 3'd1);
        waitIdle();
        checkOutput("ur_bar1_wr", 128'(ur_count), 128'(expUr));
        applyStimulus(makeDesc(4'b0001, 62'h7, 11'd1, 3'd0, 8'h22), 4'hF, 1'b1);
        expUr = satInc(expUr);
        doRead(62'h7, 4'hF, 11'd1, 3'd2, 8'h23);
        doRead(62'h7, 4'hF, 11'd1, 3'd0, 8'h24);
        waitIdle();
        checkOutput("ur_malformed", 128'(ur_count), 128'(expUr));

        // Backpressure on CC
        doWrite(62'h9, 4'hF, 32'hCAFEF00D, 3'd0);
        waitIdle();
        m_axis_cc_tready = 1'b0;
        doRead(62'h9, 4'hF, 11'd1, 3'd0, 8'h44);
        held = cplQ[cplQ.size()-1].data;
        waitCcValid();
        for (int i = 0; i < 10; i++) begin
            @(negedge user_clk);
            checkOutput("bp_cc_tvalid", 128'(m_axis_cc_tvalid), 1);
            checkOutput("bp_cc_tdata", m_axis_cc_tdata, held);
            checkOutput("bp_cq_tready", 128'(s_axis_cq_tready), 0);
        end
        @(posedge user_clk);
        #1;
        m_axis_cc_tready = 1'b1;
        waitIdle();
        checkOutput("bp_single_beat", 128'(m_axis_cc_tvalid), 0);

        // Reset while a completion is pending
        m_axis_cc_tready = 1'b0;
        doRead(62'h3, 4'hF, 11'd1, 3'd0, 8'h55);
        waitCcValid();
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_cc_tvalid", 128'(m_axis_cc_tvalid), 0);
        checkOutput("mid_rst_ur_count", 128'(ur_count), 0);
        checkOutput("mid_rst_cq_tready", 128'(s_axis_cq_tready), 0);
        cplQ.delete();
        wrQ.delete();
        for (int r = 0; r < 16; r++) modelRegs[r] = 32'd0;
        expUr = 0;
        repeat (2) @(posedge user_clk);
        #1;
        reset_n = 1'b1;
        m_axis_cc_tready = 1'b1;
        repeat (2) @(posedge user_clk);
        #1;
        doRead(62'h3, 4'hF, 11'd1, 3'd0, 8'h56);
        doRead(62'h9, 4'hF, 11'd1, 3'd0, 8'h57);
        waitIdle();

        // IO requests and unknown type with multi-beat drain
        doOther(4'b0010, 1, 8'h61);
        doOther(4'b1100, 3, 8'h62);
        waitIdle();
        checkOutput("ur_io_drop", 128'(ur_count), 128'(expUr));
        doOther(4'b0011, 2, 8'h63);
        waitIdle();

        // Saturation of the UR counter
        for (int i = 0; i < 260; i++) doOther(4'b1100, 1, 8'h70);
        waitIdle();
        checkOutput("ur_saturate", 128'(ur_count), 128'(expUr));

        doWrite(62'hF, 4'b0011, 32'h0000ABCD, 3'd0);
        doRead(62'hF, 4'b0011, 11'd1, 3'd0, 8'h7E);
        waitIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
